// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter between NUM_REQ requesters and the async FIFO write port.
// Optional feature: define WR_ARB_ERR_CNT_EN to build the saturating write-error counter.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     enable_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic                     full_i,
  input  logic                     wr_error_i,
  output logic                     wr_en_o,
  output logic [WIDTH-1:0]         wdata_o,
  output logic [NUM_REQ-1:0]       grant_o,
  output logic                     busy_o,
  output logic [ERR_CNT_W-1:0]     err_cnt_o
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state;
  logic [PTR_W-1:0]   rr_ptr;
  logic [CNT_W-1:0]   beat_cnt;
  logic               win_found;
  logic [PTR_W-1:0]   win_idx;
  logic [PTR_W-1:0]   win_next;
  logic               valid_g;
  logic               beat_ok;
  logic [WIDTH-1:0]   data_g;

  // Search requesters starting at rr_ptr and wrapping; first valid one wins.
  always_comb begin
    logic [PTR_W-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
    win_next = PTR_W'((int'(win_idx) + 1) % NUM_REQ);
  end

  always_comb begin
    data_g = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (grant_o[r]) data_g = req_data_i[r*WIDTH +: WIDTH];
    end
  end

  // grant_o is zero outside BURST, so the handshake needs no extra state qualification.
  assign valid_g     = |(req_valid_i & grant_o);
  assign beat_ok     = busy_o & valid_g & ~full_i;
  assign req_ready_o = (busy_o && !full_i) ? grant_o : '0;
  assign wr_en_o     = beat_ok;
  assign wdata_o     = beat_ok ? data_g : '0;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state    <= IDLE;
      grant_o  <= '0;
      busy_o   <= 1'b0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable_i && win_found) begin
            state    <= BURST;
            grant_o  <= NUM_REQ'(1) << win_idx;
            busy_o   <= 1'b1;
            rr_ptr   <= win_next;
            beat_cnt <= '0;
          end
        end
        BURST: begin
          // While full, everything holds, including a dropped valid.
          if (!full_i) begin
            if (valid_g) begin
              beat_cnt <= beat_cnt + CNT_W'(1);
              if (beat_cnt == LAST_BEAT) begin
                state   <= IDLE;
                grant_o <= '0;
                busy_o  <= 1'b0;
              end
            end else begin
              state   <= IDLE;
              grant_o <= '0;
              busy_o  <= 1'b0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          grant_o <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

`ifdef WR_ARB_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_cnt <= '0;
    end else if (wr_error_i && (err_cnt != {ERR_CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  assign err_cnt_o = err_cnt;
`else
  logic unused_wr_error;
  assign unused_wr_error = wr_error_i;
  assign err_cnt_o       = '0;
`endif

endmodule
